// File: rtl/tma_uop_gather_pkg.sv
// Shared TMA launch uop encodings and per-warp gather context states.
package tma_uop_gather_pkg;

  localparam logic [2:0] TMA_OP_SETUP0  = 3'd0;
  localparam logic [2:0] TMA_OP_SETUP1  = 3'd1;
  localparam logic [2:0] TMA_OP_COORD01 = 3'd2;
  localparam logic [2:0] TMA_OP_COORD23 = 3'd3;
  localparam logic [2:0] TMA_OP_ISSUE   = 3'd4;

  localparam int TMA_NUM_COORDS = 5;

  // State encoding equals the op code each state is waiting for.
  typedef enum logic [2:0] {
    EXP_SETUP0 = 3'd0,
    EXP_SETUP1 = 3'd1,
    EXP_C01    = 3'd2,
    EXP_C23    = 3'd3,
    EXP_ISSUE  = 3'd4
  } tma_ctx_state_e;

  function automatic tma_ctx_state_e tma_next_exp(input tma_ctx_state_e s);
    case (s)
      EXP_SETUP0: tma_next_exp = EXP_SETUP1;
      EXP_SETUP1: tma_next_exp = EXP_C01;
      EXP_C01:    tma_next_exp = EXP_C23;
      EXP_C23:    tma_next_exp = EXP_ISSUE;
      default:    tma_next_exp = EXP_SETUP0;
    endcase
  endfunction

endpackage

// File: rtl/tma_leader_sel.sv
// Picks the lowest active lane of a thread mask (lane 0 when empty) and
// returns that lane's rs1/rs2 words. Purely combinational.
module tma_leader_sel #(
  parameter int NUM_THREADS = 4,
  parameter int XLEN        = 32
) (
  input  logic [NUM_THREADS-1:0]      tmask,
  input  logic [NUM_THREADS*XLEN-1:0] rs1_data,
  input  logic [NUM_THREADS*XLEN-1:0] rs2_data,
  output logic [XLEN-1:0]             rs1,
  output logic [XLEN-1:0]             rs2
);

  logic found;

  always_comb begin
    found = 1'b0;
    rs1   = rs1_data[XLEN-1:0];
    rs2   = rs2_data[XLEN-1:0];
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (tmask[i] && !found) begin
        found = 1'b1;
        rs1   = rs1_data[i*XLEN +: XLEN];
        rs2   = rs2_data[i*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/tma_uop_gather.sv
// Collects the five-uop TMA launch sequence per warp and emits one registered
// request on ISSUE (latency 1, single-entry output buffer, ISSUE stalls only).
module tma_uop_gather
  import tma_uop_gather_pkg::*;
#(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int XLEN        = 32,
  parameter int UUID_WIDTH  = 44,
  localparam int WID_W      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [2:0]                     in_op,
  input  logic [WID_W-1:0]               in_wid,
  input  logic [NUM_THREADS-1:0]         in_tmask,
  input  logic [UUID_WIDTH-1:0]          in_uuid,
  input  logic [NUM_THREADS*XLEN-1:0]    in_rs1_data,
  input  logic [NUM_THREADS*XLEN-1:0]    in_rs2_data,
  output logic                           req_valid,
  input  logic                           req_ready,
  output logic [WID_W-1:0]               req_wid,
  output logic [NUM_THREADS-1:0]         req_tmask,
  output logic [UUID_WIDTH-1:0]          req_uuid,
  output logic [XLEN-1:0]                req_meta,
  output logic [XLEN-1:0]                req_smem_addr,
  output logic [TMA_NUM_COORDS*XLEN-1:0] req_coords,
  output logic [NUM_WARPS-1:0]           pending,
  output logic                           err_valid,
  output logic [WID_W-1:0]               err_wid
);

  typedef struct packed {
    logic [WID_W-1:0]                     wid;
    logic [NUM_THREADS-1:0]               tmask;
    logic [UUID_WIDTH-1:0]                uuid;
    logic [XLEN-1:0]                      meta;
    logic [XLEN-1:0]                      smem_addr;
    logic [TMA_NUM_COORDS-1:0][XLEN-1:0]  coords;
  } tma_req_t;

  tma_ctx_state_e       state_q [NUM_WARPS];
  tma_ctx_state_e       state_d [NUM_WARPS];
  tma_ctx_state_e       cur_state;
  logic [XLEN-1:0]      meta_q  [NUM_WARPS];
  logic [XLEN-1:0]      smem_q  [NUM_WARPS];
  logic [3:0][XLEN-1:0] coord_q [NUM_WARPS];
  tma_req_t             req_q;
  logic [XLEN-1:0]      lead_rs1, lead_rs2;
  logic                 accept, op_match, meta_bad, seq_ok, ctx_err, req_load;

  tma_leader_sel #(.NUM_THREADS(NUM_THREADS), .XLEN(XLEN)) u_leader (
    .tmask    (in_tmask),
    .rs1_data (in_rs1_data),
    .rs2_data (in_rs2_data),
    .rs1      (lead_rs1),
    .rs2      (lead_rs2)
  );

  assign cur_state = state_q[in_wid];
  assign in_ready  = (in_op != TMA_OP_ISSUE) || !req_valid || req_ready;
  assign accept    = in_valid && in_ready;
  assign op_match  = (in_op == cur_state);
  assign meta_bad  = (in_op == TMA_OP_SETUP1) && (lead_rs2 != meta_q[in_wid]);
  assign seq_ok    = op_match && !meta_bad;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < NUM_WARPS; w++) state_q[w] <= EXP_SETUP0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) state_q[w] <= state_d[w];
    end
  end

  // An out-of-order SETUP0 is treated as the start of a new sequence.
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) state_d[w] = state_q[w];
    if (accept) begin
      if (seq_ok)                          state_d[in_wid] = tma_next_exp(cur_state);
      else if (in_op == TMA_OP_SETUP0)     state_d[in_wid] = EXP_SETUP1;
      else                                 state_d[in_wid] = EXP_SETUP0;
    end
  end

  always_comb begin
    ctx_err  = accept && !seq_ok;
    req_load = accept && seq_ok && (in_op == TMA_OP_ISSUE);
    for (int w = 0; w < NUM_WARPS; w++) pending[w] = (state_q[w] != EXP_SETUP0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_valid <= 1'b0;
      err_valid <= 1'b0;
    end else begin
      req_valid <= req_load || (req_valid && !req_ready);
      err_valid <= ctx_err;
    end
  end

  // Stale data from an aborted sequence is always overwritten before reuse.
  always_ff @(posedge clk) begin
    if (accept) begin
      case (in_op)
        TMA_OP_SETUP0:  meta_q[in_wid] <= lead_rs1;
        TMA_OP_SETUP1:  smem_q[in_wid] <= lead_rs1;
        TMA_OP_COORD01: begin
          coord_q[in_wid][0] <= lead_rs1;
          coord_q[in_wid][1] <= lead_rs2;
        end
        TMA_OP_COORD23: begin
          coord_q[in_wid][2] <= lead_rs1;
          coord_q[in_wid][3] <= lead_rs2;
        end
        default: ;
      endcase
    end
    if (req_load) begin
      req_q.wid       <= in_wid;
      req_q.tmask     <= in_tmask;
      req_q.uuid      <= in_uuid;
      req_q.meta      <= meta_q[in_wid];
      req_q.smem_addr <= smem_q[in_wid];
      req_q.coords    <= {lead_rs1, coord_q[in_wid]};
    end
    if (ctx_err) err_wid <= in_wid;
  end

  assign req_wid       = req_q.wid;
  assign req_tmask     = req_q.tmask;
  assign req_uuid      = req_q.uuid;
  assign req_meta      = req_q.meta;
  assign req_smem_addr = req_q.smem_addr;
  assign req_coords    = req_q.coords;

endmodule
